act_serializer: RTL and testbench
=================================

Name: act_serializer

Overview:
- Transmit-side counterpart to the bit-serial activation quantizer.
- Accepts one parallel word of 8-bit quantized activations per lane through a valid/ready handshake.
- Emits each lane's activation bit-serially into the systolic array, 8 consecutive bits per lane, with the same per-lane skew the quantizer's staggered reset chain expects.
- Sits between the activation buffer and the array's data inputs.

Parameters:
- HEIGHT, 2, array rows; LANES = 4*HEIGHT serial lanes.
- ACT_WIDTH, 8, bits per activation; fixed at 8 for this revision.

Ports:
- clk  input  1  clock, all logic on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_data  input  8*LANES  lane l activation in bits [8l+7:8l].
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word.
- serial_out  output  LANES  one serial bit per lane.
- lane_valid  output  LANES  bit l high while lane l drives a payload bit.
- busy  output  1  high in SEND.
- done  output  1  one-cycle pulse after the last bit of a word.

Behaviour:
- Skew: lane l delay d(l) = 8*(l%4) + l/4.
  - MAX_SKEW = 24 + HEIGHT - 1.
  - TOTAL = MAX_SKEW + 8 cycles per word.
  - HEIGHT=2 gives d = 0,8,16,24,1,9,17,25 for l=0..7, and TOTAL = 33.
- States: IDLE, SEND.
- IDLE:
  - in_ready = 1.
  - busy = 0; serial_out = 0; lane_valid = 0.
  - An edge with in_valid & in_ready captures in_data into a holding register, clears counter t to 0, and moves to SEND.
  - in_valid without ready is ignored; no capture.
- SEND:
  - in_ready = 0 and busy = 1.
  - t counts 0..TOTAL-1; t=0 is the first cycle after the accepting edge.
  - Lane l, for d(l) <= t <= d(l)+7: serial_out[l] = word_l[7-(t-d(l))] (MSB first) and lane_valid[l] = 1.
  - Outside that window: serial_out[l] = 0 and lane_valid[l] = 0.
  - Outputs are registered; no combinational path from in_data or in_valid to serial_out.
  - Changes to in_data during SEND have no effect.
- End of word:
  - On the edge ending t = TOTAL-1, return to IDLE.
  - done = 1 for exactly the first IDLE cycle; in_ready is also 1 in that cycle.
  - Back-to-back: if in_valid is held, the next word is accepted on the edge ending the done cycle.
  - Gap between last bit of word N and t=0 of word N+1 is 1 cycle (the done cycle).
- Counter width: clog2(TOTAL); no wrap beyond TOTAL-1.
- Reset, at any time including mid-SEND:
  - state = IDLE, t = 0, holding register = 0.
  - serial_out = 0, lane_valid = 0, busy = 0, done = 0.
  - in_ready = 1 once reset deasserts.
  - A partially sent word is discarded and no done pulse is produced.
- Word value 0: lane windows still occur (lane_valid high) with serial_out = 0.

Optional Feature:
- Macro: ACT_SERIALIZER_LSB_FIRST_EN.
- Defined: bit order per lane is LSB first; serial_out[l] = word_l[t-d(l)] inside the window.
- Undefined: MSB first as above.
- Timing, skew, handshake and done are identical in both builds.

Test Plan:
- Single word, HEIGHT=2, lane0 = 0xA5, lane4 = 0x80, others 0, in_valid one cycle in IDLE:
  - lane0 emits 1,0,1,0,0,1,0,1 at t=0..7.
  - lane4 emits 1 at t=1 only; lane_valid[4] high t=1..8.
  - lane7 lane_valid high t=25..32.
  - done at cycle 33; busy high for 33 cycles.
- Skew check, all lanes 0xFF:
  - lane l serial_out high exactly during t in [d(l), d(l)+7].
  - lane_valid equals serial_out every cycle.
- Back-to-back, in_valid held, words 0x01 then 0xFE on lane1:
  - Second word's t=0 falls exactly 34 cycles after the first's t=0.
  - lane1 shows 00000001 then 11111110 starting t=8.
- Backpressure: in_valid asserted at t=5 of SEND with a new in_data:
  - Not captured; in_ready stays 0.
  - Word is captured only at the done-cycle edge.
- Reset mid-operation: assert reset at t=12 for 2 cycles:
  - All outputs 0 immediately (asynchronous).
  - No done pulse; in_ready = 1 after release.
  - Next word starts cleanly at t=0.
- LSB-first build: lane0 = 0xA5 emits 1,0,1,0,0,1,0,1 (0xA5 is a bit palindrome); lane0 = 0x01 emits 1 at t=0 only.

Source files
------------

// File: rtl/act_serializer_if.sv
// act_serializer_if: parallel-in / bit-serial-out bundle for act_serializer.
// Handshake: a word transfers on any rising clk edge where in_valid and
// in_ready are both high; in_valid may rise at any time and is ignored while
// in_ready is low, and in_data only needs to be stable on the transfer edge.
// fsm_state mirrors the serializer's state register for observation.
interface act_serializer_if #(
    parameter int HEIGHT    = 2,
    parameter int ACT_WIDTH = 8
);
    localparam int LANES = 4 * HEIGHT;

    logic [ACT_WIDTH*LANES-1:0] in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES-1:0]           serial_out;
    logic [LANES-1:0]           lane_valid;
    logic                       busy;
    logic                       done;
    logic                       fsm_state;

    // Serializer side.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output serial_out,
        output lane_valid,
        output busy,
        output done,
        output fsm_state
    );

    // Buffer / array side.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  serial_out,
        input  lane_valid,
        input  busy,
        input  done,
        input  fsm_state
    );
endinterface

// File: rtl/act_serializer.sv
// act_serializer: takes one parallel word of 8-bit activations (one per lane)
// and shifts each lane out bit-serially into the systolic array, lane l
// delayed by d(l) = 8*(l%4) + l/4 cycles to match the quantizer's staggered
// reset chain. A word occupies TOTAL = 24 + HEIGHT - 1 + 8 cycles in SEND,
// followed by a one-cycle done pulse in IDLE.
// Build option: define ACT_SERIALIZER_LSB_FIRST_EN to send each lane LSB first
// instead of MSB first; timing, skew and handshake do not change.
module act_serializer #(
    parameter int HEIGHT    = 2,
    parameter int ACT_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    act_serializer_if.slave  bus
);
    localparam int W        = ACT_WIDTH;
    localparam int LANES    = 4 * HEIGHT;
    localparam int MAX_SKEW = 3 * W + HEIGHT - 1;
    localparam int TOTAL    = MAX_SKEW + W;
    localparam int CNT_W    = $clog2(TOTAL);
    localparam int DIFF_W   = CNT_W + 1;
    localparam int POS_W    = $clog2(W);

    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TOTAL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     t;
    logic [CNT_W-1:0]     t_next;
    logic [W*LANES-1:0]   word;
    logic [W*LANES-1:0]   word_next;
    logic                 done_next;

    logic [LANES-1:0]     lane_win;
    logic [LANES-1:0]     lane_bit;
    logic [LANES-1:0]     ser_next;

    logic [LANES-1:0]     ser_q;
    logic [LANES-1:0]     vld_q;
    logic                 busy_q;
    logic                 done_q;

    // State, cycle counter and holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            t     <= '0;
            word  <= '0;
        end else begin
            state <= state_next;
            t     <= t_next;
            word  <= word_next;
        end
    end

    // Next-state logic: capture in IDLE, count through SEND, pulse done on exit.
    always_comb begin
        state_next = state;
        t_next     = t;
        word_next  = word;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next = SEND;
                    t_next     = '0;
                    word_next  = bus.in_data;
                end
            end
            SEND: begin
                if (t == T_LAST) begin
                    state_next = IDLE;
                    t_next     = '0;
                    done_next  = 1'b1;
                end else begin
                    t_next = t + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                t_next     = '0;
            end
        endcase
    end

    // Per-lane window decode. Outputs are computed from the *next* state so
    // that the registered serial bits line up with t on the same cycle; the
    // path from in_data always passes through the output registers.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int               DELAY   = W * (l % 4) + l / 4;
        localparam logic [DIFF_W-1:0] DELAY_V = DIFF_W'(DELAY);
        localparam logic [DIFF_W-1:0] WIN_LEN = DIFF_W'(W);

        logic [DIFF_W-1:0] rel;
        logic [POS_W-1:0]  pos;
        logic [W-1:0]      lane_word;

        // rel wraps to a large value (top bit set) before the window opens,
        // so a single unsigned compare covers both window edges.
        assign rel       = {1'b0, t_next} - DELAY_V;
        assign pos       = rel[POS_W-1:0];
        assign lane_word = word_next[W*l +: W];
        assign lane_win[l] = (state_next == SEND) && (rel < WIN_LEN);
`ifdef ACT_SERIALIZER_LSB_FIRST_EN
        assign lane_bit[l] = lane_word[pos];
`else
        assign lane_bit[l] = lane_word[POS_W'(W - 1) - pos];
`endif
    end

    assign ser_next = lane_bit & lane_win;

    // Registered outputs; everything drops to zero outside SEND.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ser_q  <= '0;
            vld_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ser_q  <= ser_next;
            vld_q  <= lane_win;
            busy_q <= (state_next == SEND);
            done_q <= done_next;
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.serial_out = ser_q;
    assign bus.lane_valid = vld_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.fsm_state  = state;

endmodule

// File: tb/tb_act_serializer.sv
// tb_act_serializer: directed bench for act_serializer with HEIGHT=2
// (8 lanes, TOTAL = 33 cycles per word). Build with
// ACT_SERIALIZER_LSB_FIRST_EN defined to check the LSB-first ordering.
module tb_act_serializer;
    localparam int HEIGHT = 2;
    localparam int LANES  = 4 * HEIGHT;
    localparam int TOTAL  = 33;

    // Hand-computed lane delays for HEIGHT=2.
    localparam int D_TAB [8] = '{0, 8, 16, 24, 1, 9, 17, 25};

`ifdef ACT_SERIALIZER_LSB_FIRST_EN
    localparam int LANE4_ONE_T = 8;   // 0x80 LSB first: the 1 is the last bit
    localparam int W01_ONE_T   = 0;   // 0x01 LSB first: the 1 is the first bit
`else
    localparam int LANE4_ONE_T = 1;   // 0x80 MSB first: the 1 is the first bit of lane4 (d=1)
    localparam int W01_ONE_T   = 7;   // 0x01 MSB first: the 1 is the last bit
`endif

    logic clk;
    logic reset;

    act_serializer_if #(.HEIGHT(HEIGHT), .ACT_WIDTH(8)) bus ();

    act_serializer #(.HEIGHT(HEIGHT), .ACT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests;
    int n_fail;

    logic [7:0] got_ser [0:TOTAL-1];
    logic [7:0] got_vld [0:TOTAL-1];
    int         busy_cnt;
    logic [7:0] exp_q [$];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour for one cycle of SEND at counter value t.
    function automatic void model(input logic [63:0] w, input int t,
                                  output logic [7:0] ser, output logic [7:0] vld);
        logic [63:0] sh;
        logic [7:0]  lane_byte;
        logic [7:0]  tmp;
        int          k;
        ser = '0;
        vld = '0;
        for (int l = 0; l < LANES; l++) begin
            k = t - D_TAB[l];
            if (k >= 0 && k < 8) begin
                sh        = w >> (8 * l);
                lane_byte = sh[7:0];
`ifdef ACT_SERIALIZER_LSB_FIRST_EN
                tmp = lane_byte >> k;
`else
                tmp = lane_byte >> (7 - k);
`endif
                vld[l] = 1'b1;
                ser[l] = tmp[0];
            end
        end
    endfunction

    // Steps to the next sample point, #1 after the active edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Checks one full SEND period of word w against the model; the caller has
    // just crossed the accepting edge, so the current sample is t=0.
    task automatic check_send(input logic [63:0] w, input string tag);
        logic [7:0] es;
        logic [7:0] ev;
        busy_cnt = 0;
        for (int t = 0; t < TOTAL; t++) begin
            model(w, t, es, ev);
            got_ser[t] = bus.serial_out;
            got_vld[t] = bus.lane_valid;
            if (bus.busy) busy_cnt++;
            check({tag, "_ser"}, bus.serial_out, es);
            check({tag, "_vld"}, bus.lane_valid, ev);
            if (t == 0 || t == TOTAL - 1) begin
                check({tag, "_ready_send"}, bus.in_ready, 1'b0);
                check({tag, "_done_send"}, bus.done, 1'b0);
            end
            next_cycle();
        end
        check({tag, "_busy_cnt"}, busy_cnt, TOTAL);
    endtask

    // Single word from IDLE with a one-cycle in_valid; ends one cycle after done.
    task automatic run_word(input logic [63:0] w, input string tag);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        next_cycle();
        bus.in_valid = 1'b0;
        check_send(w, tag);
        check({tag, "_done"}, bus.done, 1'b1);
        check({tag, "_busy_end"}, bus.busy, 1'b0);
        check({tag, "_ready_end"}, bus.in_ready, 1'b1);
        check({tag, "_vld_end"}, bus.lane_valid, 8'h00);
        next_cycle();
        check({tag, "_done_once"}, bus.done, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] pat;
        logic [7:0] sh8;
        int         nb;
        int         starts [2];
        int         nstart;
        int         cnt_done;
        int         cnt_busy;

        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ser", bus.serial_out, 8'h00);
        check("rst_vld", bus.lane_valid, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_state", bus.fsm_state, 1'b0);
        reset = 1'b0;
        next_cycle();
        check("rst_ready", bus.in_ready, 1'b1);

        // Test 1: lane0 = 0xA5, lane4 = 0x80.
        run_word(64'h0000_0080_0000_00A5, "t1");
        pat = 8'b1010_0101;
        for (int t = 0; t < 8; t++)
            check("t1_lane0_bit", got_ser[t][0], pat[7 - t]);
        for (int t = 0; t < TOTAL; t++) begin
            check("t1_lane4_ser", got_ser[t][4], (t == LANE4_ONE_T));
            check("t1_lane4_vld", got_vld[t][4], (t >= 1 && t <= 8));
            check("t1_lane7_vld", got_vld[t][7], (t >= 25 && t <= 32));
        end

        // Test 2: all lanes 0xFF, serial_out must equal lane_valid.
        run_word(64'hFFFF_FFFF_FFFF_FFFF, "t2");
        for (int t = 0; t < TOTAL; t++)
            check("t2_ser_eq_vld", got_ser[t], got_vld[t]);
        for (int l = 0; l < LANES; l++) begin
            check("t2_win_first", got_ser[D_TAB[l]][l], 1'b1);
            check("t2_win_last", got_ser[D_TAB[l] + 7][l], 1'b1);
            if (D_TAB[l] > 0)
                check("t2_win_before", got_ser[D_TAB[l] - 1][l], 1'b0);
            if (D_TAB[l] + 8 < TOTAL)
                check("t2_win_after", got_ser[D_TAB[l] + 8][l], 1'b0);
        end

        // Test 3: zero word still opens every lane window.
        run_word(64'h0, "t3");
        for (int t = 0; t < TOTAL; t++)
            check("t3_zero_ser", got_ser[t], 8'h00);

        // Test 4: back-to-back, in_valid held, lane1 = 0x01 then 0xFE.
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFE);
        bus.in_data  = 64'h0000_0000_0000_0100;
        bus.in_valid = 1'b1;
        next_cycle();
        bus.in_data  = 64'h0000_0000_0000_FE00;
        nb     = 0;
        nstart = 0;
        sh8    = '0;
        for (int c = 0; c < 70; c++) begin
            if (c == 33) begin
                check("t4_gap_vld", bus.lane_valid, 8'h00);
                check("t4_gap_done", bus.done, 1'b1);
                check("t4_gap_ready", bus.in_ready, 1'b1);
            end
            if (c == 34) begin
                check("t4_second_t0_vld", bus.lane_valid, 8'h01);
                check("t4_second_busy", bus.busy, 1'b1);
                bus.in_valid = 1'b0;
            end
            if (c == 67) check("t4_final_done", bus.done, 1'b1);
            if (bus.lane_valid[1]) begin
                if (nb == 0 && nstart < 2) begin
                    starts[nstart] = c;
                    nstart++;
                end
                sh8 = {sh8[6:0], bus.serial_out[1]};
                nb++;
                if (nb == 8) begin
                    if (exp_q.size() == 0) begin
                        check("t4_extra_word", sh8, 8'hxx);
                    end else begin
`ifdef ACT_SERIALIZER_LSB_FIRST_EN
                        check("t4_lane1_word", {<<{sh8}}, exp_q.pop_front());
`else
                        check("t4_lane1_word", sh8, exp_q.pop_front());
`endif
                    end
                    nb = 0;
                end
            end
            next_cycle();
        end
        check("t4_words_left", exp_q.size(), 0);
        check("t4_window_count", nstart, 2);
        check("t4_first_start", starts[0], 8);
        check("t4_second_start", starts[1], 42);

        // Test 5: backpressure; new word offered at t=5 is held off until done.
        bus.in_data  = 64'h0000_0000_003C_0000;
        bus.in_valid = 1'b1;
        next_cycle();
        bus.in_valid = 1'b0;
        for (int t = 0; t < TOTAL; t++) begin
            logic [7:0] es;
            logic [7:0] ev;
            model(64'h0000_0000_003C_0000, t, es, ev);
            check("t5_a_ser", bus.serial_out, es);
            check("t5_a_vld", bus.lane_valid, ev);
            if (t >= 5) check("t5_ready_low", bus.in_ready, 1'b0);
            if (t == 5) begin
                bus.in_data  = 64'h0000_0000_00C3_0000;
                bus.in_valid = 1'b1;
            end
            next_cycle();
        end
        check("t5_done", bus.done, 1'b1);
        check("t5_ready_done", bus.in_ready, 1'b1);
        check("t5_busy_done", bus.busy, 1'b0);
        next_cycle();
        bus.in_valid = 1'b0;
        check_send(64'h0000_0000_00C3_0000, "t5_b");
        check("t5_b_done", bus.done, 1'b1);
        next_cycle();

        // Test 6: asynchronous reset at t=12, held two cycles.
        bus.in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.in_valid = 1'b1;
        next_cycle();
        bus.in_valid = 1'b0;
        repeat (12) next_cycle();
        check("t6_pre_busy", bus.busy, 1'b1);
        reset = 1'b1;
        #1;
        check("t6_async_ser", bus.serial_out, 8'h00);
        check("t6_async_vld", bus.lane_valid, 8'h00);
        check("t6_async_busy", bus.busy, 1'b0);
        check("t6_async_done", bus.done, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        next_cycle();
        check("t6_ready_after", bus.in_ready, 1'b1);
        cnt_done = 0;
        cnt_busy = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) cnt_done++;
            if (bus.busy) cnt_busy++;
            next_cycle();
        end
        check("t6_no_done", cnt_done, 0);
        check("t6_no_busy", cnt_busy, 0);
        run_word(64'h0000_0000_0000_0081, "t6_next");
        pat = 8'b1000_0001;
        for (int t = 0; t < 8; t++)
            check("t6_lane0_bit", got_ser[t][0], pat[7 - t]);

        // Test 7: bit ordering of lane0 = 0x01.
        run_word(64'h0000_0000_0000_0001, "t7");
        for (int t = 0; t < 8; t++)
            check("t7_lane0_order", got_ser[t][0], (t == W01_ONE_T));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
